mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 43 ++++
 rtl/mdu_ctrl_if.sv | 31 +++
 rtl/mdu_ctrl_div_core.sv | 51 +++++
 rtl/mdu_ctrl.sv | 113 +++++++++++
 tb/tb_mdu_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide unit controller.
// Holds the MDU operation codes, the controller state enum, the data and
// result widths, the divide iteration count, and small sign helpers used by
// both the controller and its testbench.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DIV_FIX = 2'd2,
    DONE    = 2'd3
  } mdu_state_e;

  localparam int DATA_W   = 32;
  localparam int RES_W    = 64;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  // Two's-complement negate when n is set.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic n);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    return n ? DATA_W'(-sv) : v;
  endfunction

  // Magnitude of v; treated as signed only when is_signed is set.
  // The most-negative value maps to itself, which is the correct unsigned
  // magnitude 2^31.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                            input logic is_signed);
    return cond_neg(v, is_signed & v[DATA_W-1]);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage <-> MDU bundle.
//   start, op, opa, opb, flush : request side, driven by the pipeline (master)
//   stall, done                : pipeline hold and completion pulse
//   mullo, mulhi, mul_s        : registered partial products and sign flag
//   divres                     : {remainder, quotient}
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic                start;
  mdu_op_e             op;
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic                flush;
  logic                stall;
  logic                done;
  logic [RES_W-1:0]    mullo;
  logic [RES_W-1:0]    mulhi;
  logic                mul_s;
  logic [RES_W-1:0]    divres;

  modport master (
    output start, op, opa, opb, flush,
    input  stall, done, mullo, mulhi, mul_s, divres
  );

  modport slave (
    input  start, op, opa, opb, flush,
    output stall, done, mullo, mulhi, mul_s, divres
  );

endinterface

// File: rtl/mdu_ctrl_div_core.sv
// div_core: unsigned restoring radix-2 divider datapath.
//   clk      : clock
//   load     : capture dividend/divisor, clear partial remainder
//   en       : perform one quotient-bit step
//   dividend : unsigned dividend magnitude
//   divisor  : unsigned divisor magnitude (nonzero)
//   quot     : quotient (valid after DIV_ITER enabled steps)
//   rem      : remainder (valid after DIV_ITER enabled steps)
// Sequencing and sign handling belong to the caller; no reset is needed
// because results are only consumed after a full load + iterate sequence.
module div_core
  import mdu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  logic [DATA_W-1:0] dsr;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder each step while the new quotient bit enters at the LSB.
  // trial[DATA_W] set means the subtraction borrowed (restore).
  always_comb begin
    shifted = {rem, quot[DATA_W-1]};
    trial   = shifted - {1'b0, dsr};
  end

  always_ff @(posedge clk) begin
    if (load) begin
      rem  <= '0;
      quot <= dividend;
      dsr  <= divisor;
    end else if (en) begin
      if (!trial[DATA_W]) begin
        rem  <= trial[DATA_W-1:0];
        quot <= {quot[DATA_W-2:0], 1'b1};
      end else begin
        rem  <= shifted[DATA_W-1:0];
        quot <= {quot[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : mdu_ctrl_if.slave -- start/op/opa/opb/flush in,
//         stall/done/mullo/mulhi/mul_s/divres out
// Multiplies complete in one cycle as four registered 16x16 partial products
// of the operand magnitudes. Divides run through div_core for DIV_ITER
// cycles, then a fix-up cycle applies signs before the done pulse.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mdu_ctrl_if.slave bus
);

  mdu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              is_mul, is_div, is_signed, div_zero, accept;
  logic              mul_done, neg_q, neg_r;
  logic [DATA_W-1:0] ma, mb;
  logic [DATA_W-1:0] pp_ll, pp_hl, pp_lh, pp_hh;
  logic [DATA_W-1:0] qmag, rmag;

  always_comb begin
    is_mul    = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
    is_div    = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
    is_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    div_zero  = (bus.opb == '0);
    accept    = (state == IDLE) && bus.start && !bus.flush && (is_mul || is_div);
    ma        = mag(bus.opa, is_signed);
    mb        = mag(bus.opb, is_signed);
    pp_ll     = {16'd0, ma[15:0]}  * {16'd0, mb[15:0]};
    pp_hl     = {16'd0, ma[31:16]} * {16'd0, mb[15:0]};
    pp_lh     = {16'd0, ma[15:0]}  * {16'd0, mb[31:16]};
    pp_hh     = {16'd0, ma[31:16]} * {16'd0, mb[31:16]};
  end

  div_core u_div_core (
    .clk      (clk),
    .load     (accept && is_div && !div_zero),
    .en       (state == DIV_RUN),
    .dividend (ma),
    .divisor  (mb),
    .quot     (qmag),
    .rem      (rmag)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush wins over everything except reset.
  // Multiplies never leave IDLE; a zero divisor goes straight to DONE.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && is_div) state_nxt = div_zero ? DONE : DIV_RUN;
        DIV_RUN: if (cnt == CNT_W'(DIV_ITER - 1)) state_nxt = DIV_FIX;
        DIV_FIX: state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs; stall rises in the accept cycle so the EX stage holds at once.
  always_comb begin
    bus.stall = (state == DIV_RUN) || (state == DIV_FIX) ||
                (accept && is_div && !div_zero);
    bus.done  = (state == DONE) || mul_done;
  end

  // Counter, sign latches and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      mul_done   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      bus.mul_s  <= 1'b0;
      bus.mullo  <= '0;
      bus.mulhi  <= '0;
      bus.divres <= '0;
    end else begin
      mul_done <= accept && is_mul;

      if (accept)                cnt <= '0;
      else if (state == DIV_RUN) cnt <= cnt + CNT_W'(1);

      if (accept && is_mul) begin
        bus.mullo <= {pp_hl, pp_ll};
        bus.mulhi <= {pp_hh, pp_lh};
        bus.mul_s <= (bus.op == MDU_MULT) && (bus.opa[31] ^ bus.opb[31]);
      end

      if (accept && is_div) begin
        neg_q <= (bus.op == MDU_DIV) && (bus.opa[31] ^ bus.opb[31]);
        neg_r <= (bus.op == MDU_DIV) && bus.opa[31];
        if (div_zero) bus.divres <= {bus.opa, 32'hFFFF_FFFF};
      end

      if (state == DIV_FIX && !bus.flush)
        bus.divres <= {cond_neg(rmag, neg_r), cond_neg(qmag, neg_q)};
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized + directed bench for mdu_ctrl with a behavioural
// reference model using plain 64-bit arithmetic.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_ctrl_if bus_if();
  mdu_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] e_mullo, e_mulhi, e_divres;
  logic        e_muls;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] absval(input logic [31:0] v, input bit sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Expected architectural results of one completing operation.
  task automatic model(input mdu_op_e o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, al, ah, bl, bh, q, r;
    longint sa, sb;
    if (o == MDU_MULT || o == MDU_MULTU) begin
      ma = absval(a, o == MDU_MULT);
      mb = absval(b, o == MDU_MULT);
      al = ma & 32'h0000FFFF; ah = ma >> 16;
      bl = mb & 32'h0000FFFF; bh = mb >> 16;
      e_mullo = {ah * bl, al * bl};
      e_mulhi = {ah * bh, al * bh};
      e_muls  = (o == MDU_MULT) && (a[31] != b[31]);
    end else if (b == 32'd0) begin
      e_divres = {a, 32'hFFFFFFFF};
    end else begin
      if (o == MDU_DIV) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      e_divres = {r, q};
    end
  endtask

  // Full product recombined from the DUT's halves, compared with a direct
  // 64-bit multiply of the original operands.
  task automatic chk_product(input string tag, input mdu_op_e o,
                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, want;
    p = {32'd0, bus_if.mullo[31:0]}
      + (({32'd0, bus_if.mullo[63:32]} + {32'd0, bus_if.mulhi[31:0]}) << 16)
      + ({32'd0, bus_if.mulhi[63:32]} << 32);
    if (bus_if.mul_s) p = 64'd0 - p;
    if (o == MDU_MULT) want = 64'(longint'($signed(a)) * longint'($signed(b)));
    else               want = {32'd0, a} * {32'd0, b};
    chk({tag, ".product"}, p, want);
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic do_op(input string tag, input mdu_op_e o,
                       input logic [31:0] a, input logic [31:0] b);
    bit is_div, long_div;
    int lat, bad_stall, bad_done;
    is_div    = (o == MDU_DIV || o == MDU_DIVU);
    long_div  = is_div && (b != 32'd0);
    lat       = long_div ? 34 : 1;
    bad_stall = 0;
    bad_done  = 0;
    bus_if.start = 1'b1; bus_if.op = o; bus_if.opa = a; bus_if.opb = b;
    bus_if.flush = 1'b0;
    model(o, a, b);
    @(negedge clk);
    if (bus_if.stall !== long_div) bad_stall++;
    if (bus_if.done !== 1'b0) bad_done++;
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      // Requests while busy must be ignored.
      if (is_div && c <= lat) begin
        bus_if.start = 1'b1;
        bus_if.op    = mdu_op_e'($urandom_range(1, 4));
        bus_if.opa   = $urandom;
        bus_if.opb   = $urandom;
      end else begin
        bus_if.start = 1'b0;
        bus_if.op    = MDU_NOP;
      end
      @(negedge clk);
      if (bus_if.stall !== (long_div && c <= 33)) bad_stall++;
      if (bus_if.done !== (c == lat)) bad_done++;
      if (c == lat) begin
        chk({tag, ".mullo"},  bus_if.mullo,  e_mullo);
        chk({tag, ".mulhi"},  bus_if.mulhi,  e_mulhi);
        chk({tag, ".mul_s"},  64'(bus_if.mul_s), 64'(e_muls));
        chk({tag, ".divres"}, bus_if.divres, e_divres);
        if (!is_div) chk_product(tag, o, a, b);
      end
    end
    chk({tag, ".stall_cycles"}, 64'(bad_stall), 64'd0);
    chk({tag, ".done_cycles"},  64'(bad_done),  64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".done"},   64'(bus_if.done),  64'd0);
    chk({tag, ".stall"},  64'(bus_if.stall), 64'd0);
    chk({tag, ".mul_s"},  64'(bus_if.mul_s), 64'd0);
    chk({tag, ".mullo"},  bus_if.mullo,  64'd0);
    chk({tag, ".mulhi"},  bus_if.mulhi,  64'd0);
    chk({tag, ".divres"}, bus_if.divres, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int bad;
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.op = MDU_NOP;
    bus_if.opa = '0; bus_if.opb = '0; bus_if.flush = 1'b0;
    e_mullo = '0; e_mulhi = '0; e_divres = '0; e_muls = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed corner cases
    do_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max.lo_const", bus_if.mullo, 64'hFFFE0001_FFFE0001);
    chk("multu_max.hi_const", bus_if.mulhi, 64'hFFFE0001_FFFE0001);

    do_op("mult_m3x5", MDU_MULT, 32'hFFFFFFFD, 32'd5);
    chk("mult_m3x5.lo_const", bus_if.mullo, 64'd15);
    chk("mult_m3x5.hi_const", bus_if.mulhi, 64'd0);
    chk("mult_m3x5.sign",     64'(bus_if.mul_s), 64'd1);

    do_op("div_m7d2", MDU_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_m7d2.const", bus_if.divres, 64'hFFFFFFFF_FFFFFFFD);

    do_op("divu_by0", MDU_DIVU, 32'd100, 32'd0);
    chk("divu_by0.const", bus_if.divres, 64'h00000064_FFFFFFFF);

    do_op("div_minneg", MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("div_minneg.const", bus_if.divres, 64'h00000000_80000000);

    // flush in the same cycle as start: request dropped
    bus_if.start = 1'b1; bus_if.op = MDU_DIV; bus_if.opa = $urandom;
    bus_if.opb = 32'd5; bus_if.flush = 1'b1;
    @(negedge clk);
    chk("flush_start.stall", 64'(bus_if.stall), 64'd0);
    @(posedge clk); #1;
    bus_if.start = 1'b0; bus_if.flush = 1'b0;
    bad = 0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (bus_if.done !== 1'b0 || bus_if.stall !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("flush_start.quiet", 64'(bad), 64'd0);
    chk("flush_start.divres", bus_if.divres, e_divres);

    // flush at T+10 of a divide, MULTU at T+11
    bus_if.start = 1'b1; bus_if.op = MDU_DIV; bus_if.opa = $urandom;
    bus_if.opb = $urandom | 32'd1;
    bad = 0;
    @(negedge clk);
    if (bus_if.stall !== 1'b1) bad++;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      bus_if.flush = (c == 10);
      @(negedge clk);
      if (bus_if.stall !== 1'b1 || bus_if.done !== 1'b0) bad++;
    end
    chk("flush_mid.run", 64'(bad), 64'd0);
    @(posedge clk); #1;
    a = $urandom; b = $urandom;
    bus_if.flush = 1'b0; bus_if.start = 1'b1; bus_if.op = MDU_MULTU;
    bus_if.opa = a; bus_if.opb = b;
    model(MDU_MULTU, a, b);
    @(negedge clk);
    chk("flush_mid.stall11", 64'(bus_if.stall), 64'd0);
    chk("flush_mid.done11",  64'(bus_if.done),  64'd0);
    chk("flush_mid.divres11", bus_if.divres, e_divres);
    @(posedge clk); #1;
    bus_if.start = 1'b0; bus_if.op = MDU_NOP;
    @(negedge clk);
    chk("flush_mid.done12", 64'(bus_if.done), 64'd1);
    chk("flush_mid.mullo",  bus_if.mullo, e_mullo);
    chk("flush_mid.mulhi",  bus_if.mulhi, e_mulhi);
    chk("flush_mid.divres", bus_if.divres, e_divres);
    bad = 0;
    for (int c = 13; c <= 45; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus_if.done !== 1'b0) bad++;
    end
    chk("flush_mid.no_done", 64'(bad), 64'd0);
    @(posedge clk); #1;

    // reset at T+20 of a divide, MULTU at T+21
    bus_if.start = 1'b1; bus_if.op = MDU_DIV; bus_if.opa = $urandom;
    bus_if.opb = $urandom | 32'd1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      rst = (c == 20);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    a = $urandom; b = $urandom;
    bus_if.start = 1'b1; bus_if.op = MDU_MULTU; bus_if.opa = a; bus_if.opb = b;
    e_divres = '0;
    model(MDU_MULTU, a, b);
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    bus_if.start = 1'b0; bus_if.op = MDU_NOP;
    @(negedge clk);
    chk("rst_mid.done22", 64'(bus_if.done), 64'd1);
    chk("rst_mid.mullo",  bus_if.mullo, e_mullo);
    chk("rst_mid.mulhi",  bus_if.mulhi, e_mulhi);
    chk("rst_mid.divres", bus_if.divres, 64'd0);
    @(posedge clk); #1;

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rand%0d", i), mdu_op_e'($urandom_range(1, 4)), pick(), pick());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
